window3x3_gen: RTL
==================

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
- REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per line, minimum 3.
- REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per frame, minimum 3.
- REQ-003 SHALL have one clock and a synchronous, active-low reset; the ports are clk and rst_n.
- REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
- REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
- REQ-006 SHALL have port in_valid, input, 1 bit: in_pix is accepted this cycle.
- REQ-007 SHALL have port in_sof, input, 1 bit: start of frame; qualified by in_valid.
- REQ-008 SHALL have port in_pix, input, 8 bits: raster-order pixel.
- REQ-009 SHALL have ports win1..win9, output, 8 bits each: 3x3 window in row-major order; win1 is top-left, win5 is centre, win9 is bottom-right. These feed the 9-input sorter in1..in9 directly.
- REQ-010 SHALL have port win_valid, output, 1 bit: win1..win9 hold a complete window.

Function
- REQ-011 SHALL keep a column counter col (0..IMG_WIDTH-1) and a row counter row (0..IMG_HEIGHT-1).
  - Both advance only on accepted pixels (in_valid=1).
  - col wraps to 0 after IMG_WIDTH-1 and increments row.
  - row saturates at IMG_HEIGHT-1.
- REQ-012 SHALL treat an accepted pixel with in_sof=1 as position (0,0), mid-frame included; counters continue from (0,1).
- REQ-013 SHALL keep two line buffers of IMG_WIDTH x 8 bits.
  - LB0 holds the previous line; LB1 holds the line before that.
  - On an accepted pixel at col c: read LB1[c] and LB0[c], then write LB1[c]=old LB0[c] and LB0[c]=in_pix in the same cycle (read-before-write).
- REQ-014 SHALL shift a 3x3 register array one column on each accepted pixel.
  - New right column = {LB1[c], LB0[c], in_pix} as top, middle, bottom.
  - Array is unchanged when in_valid=0.
- REQ-015 SHALL assert win_valid for exactly one cycle, in the cycle after an accepted pixel whose position has row>=2 and col>=2.
  - Latency: 1 clock from that pixel to window.
  - Result: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- REQ-016 SHALL hold win1..win9 stable when win_valid=0.
- REQ-017 SHALL drop border positions: no padding, and no window is emitted for row<2 or col<2.
- REQ-018 SHALL never emit a window mixing two frames.
  - An in_sof restart suppresses win_valid until row>=2 and col>=2 of the new frame.
  - Stale line-buffer contents are don't-care.
- REQ-019 SHALL accept one pixel per cycle with no backpressure; arbitrary in_valid gaps SHALL not change the window sequence.

Reset
- REQ-020 SHALL, while rst_n=0 at a clk edge, set col=0, row=0, win_valid=0, win1..win9=0, and window array=0.
- REQ-021 SHALL NOT reset line-buffer contents.
- REQ-022 SHALL restart on reset mid-frame: the next accepted pixel is (0,0), whether or not in_sof is set.

Configuration
- REQ-023 SHALL, when WIN_EOF_EN is defined, add output win_eof (1 bit, reset 0).
  - win_eof pulses for one cycle, coincident with win_valid, for the window whose source pixel is at (IMG_HEIGHT-1, IMG_WIDTH-1).
  - row then stays saturated until in_sof.
- REQ-024 SHALL, when WIN_EOF_EN is undefined, have no win_eof port and no extra logic; all other behaviour is identical.

Structure
- REQ-025 SHALL place PIX_W=8, WIN_N=9, and the default width/height constants in the shared package win_pkg.
- REQ-026 SHALL implement each line buffer as one sub-module, win_line_buf: IMG_WIDTH-deep, 8 bits wide, one address, read-before-write, no reset. It is instantiated twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = raster index)
- REQ-027 SHALL cover the first window:
  - Stimulus: reset, then in_sof with pixel 0, then 1..15 back-to-back.
  - Response: first win_valid is 1 cycle after pixel 10, with win1..win9 = 0,1,2,4,5,6,8,9,10.
  - Response: then 1,2,3,5,6,7,9,10,11, then 4..14 and 5..15 windows; exactly 4 valids in total.
- REQ-028 SHALL cover in_valid gaps:
  - Stimulus: same frame with in_valid low on every other cycle.
  - Response: identical 4 windows, each 1 cycle after its source pixel; outputs held between valids.
- REQ-029 SHALL cover a mid-frame sof:
  - Stimulus: in_sof at raster index 6, then values 100..115.
  - Response: no win_valid before new pixel 110; first window = 100,101,102,104,105,106,108,109,110.
- REQ-030 SHALL cover reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle after pixel 9.
  - Response: outputs 0 and win_valid 0; next frame behaves as in REQ-027.
- REQ-031 SHALL cover WIN_EOF_EN:
  - Stimulus: full frame.
  - Response: win_eof=1 only with the window ending in pixel 15.
  - Response: a following frame without in_sof produces no win_valid.

Source files
------------

// File: rtl/win_pkg.sv
// Shared constants and pixel type for the 3x3 window generator.
// Optional feature macro used by this slice: WIN_EOF_EN.
package win_pkg;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned WIN_N          = 9;
  localparam int unsigned WIN_DIM        = 3;
  localparam int unsigned DEF_IMG_WIDTH  = 640;
  localparam int unsigned DEF_IMG_HEIGHT = 480;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out signal bundle for window3x3_gen; win_eof exists only with WIN_EOF_EN.
interface window3x3_gen_if;
  import win_pkg::*;

  logic in_valid;
  logic in_sof;
  pix_t in_pix;
  pix_t win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic win_valid;
`ifdef WIN_EOF_EN
  logic win_eof;
`endif

  modport master (
    output in_valid, in_sof, in_pix,
    input  win1, win2, win3, win4, win5, win6, win7, win8, win9, win_valid
`ifdef WIN_EOF_EN
    , input win_eof
`endif
  );

  modport slave (
    input  in_valid, in_sof, in_pix,
    output win1, win2, win3, win4, win5, win6, win7, win8, win9, win_valid
`ifdef WIN_EOF_EN
    , output win_eof
`endif
  );

endinterface

// File: rtl/win_line_buf.sv
// One image line of pixels: single address, combinational read of the old
// contents, write at the clock edge (read-before-write). No reset.
module win_line_buf
  import win_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_IMG_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  pix_t                     wr_data,
  output pix_t                     rd_data
);

  pix_t mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window3x3_gen.sv
// Raster pixel stream to 3x3 sliding window using two line buffers; borders dropped.
// Define WIN_EOF_EN to add win_eof and hold off windows after the last pixel until in_sof.
module window3x3_gen
  import win_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_sof,
  input  pix_t in_pix,
  output pix_t win1,
  output pix_t win2,
  output pix_t win3,
  output pix_t win4,
  output pix_t win5,
  output pix_t win6,
  output pix_t win7,
  output pix_t win8,
  output pix_t win9,
  output logic win_valid
`ifdef WIN_EOF_EN
  ,
  output logic win_eof
`endif
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  pix_t          lb0_rd, lb1_rd;
  pix_t          arr     [WIN_DIM][WIN_DIM];
  pix_t          nxt     [WIN_DIM][WIN_DIM];
  pix_t          win_q   [WIN_N];
  logic          fire_ok;
  logic          fire;
  logic          pos_last;

  // An accepted start-of-frame pixel overrides the counters to (0,0).
  always_comb begin
    pos_col  = in_sof ? '0 : col;
    pos_row  = in_sof ? '0 : row;
    pos_last = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  end

  win_line_buf #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (pos_col),
    .wr_data (in_pix),
    .rd_data (lb0_rd)
  );

  win_line_buf #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (pos_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      nxt[r][0] = arr[r][1];
      nxt[r][1] = arr[r][2];
      nxt[r][2] = '0;
    end
    nxt[0][2] = lb1_rd;
    nxt[1][2] = lb0_rd;
    nxt[2][2] = in_pix;
  end

`ifdef WIN_EOF_EN
  logic done;

  always_comb fire_ok = !done;

  // After the last pixel of a frame, stay quiet until the next in_sof.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done    <= 1'b0;
      win_eof <= 1'b0;
    end else begin
      win_eof <= fire && pos_last;
      if (in_valid && in_sof)          done <= 1'b0;
      else if (in_valid && pos_last)   done <= 1'b1;
    end
  end
`else
  always_comb fire_ok = 1'b1;
`endif

  always_comb fire = in_valid && fire_ok && (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      for (int unsigned r = 0; r < WIN_DIM; r++)
        for (int unsigned c = 0; c < WIN_DIM; c++)
          arr[r][c] <= '0;
      for (int unsigned k = 0; k < WIN_N; k++)
        win_q[k] <= '0;
    end else begin
      win_valid <= fire;
      if (in_valid) begin
        if (pos_col == COL_LAST) begin
          col <= '0;
          row <= (pos_row == ROW_LAST) ? pos_row : pos_row + 1'b1;
        end else begin
          col <= pos_col + 1'b1;
          row <= pos_row;
        end
        for (int unsigned r = 0; r < WIN_DIM; r++)
          for (int unsigned c = 0; c < WIN_DIM; c++)
            arr[r][c] <= nxt[r][c];
      end
      // Output copy only moves on an emitted window, so outputs hold otherwise.
      if (fire) begin
        for (int unsigned r = 0; r < WIN_DIM; r++)
          for (int unsigned c = 0; c < WIN_DIM; c++)
            win_q[r*WIN_DIM + c] <= nxt[r][c];
      end
    end
  end

  assign win1 = win_q[0];
  assign win2 = win_q[1];
  assign win3 = win_q[2];
  assign win4 = win_q[3];
  assign win5 = win_q[4];
  assign win6 = win_q[5];
  assign win7 = win_q[6];
  assign win8 = win_q[7];
  assign win9 = win_q[8];

endmodule
